// File: rtl/seg_value_driver.sv
// seg_value_driver
// Converts a 14-bit binary value to four BCD digits with a sequential
// double-dabble engine and drives the active-low seven-segment cathodes
// for the digit currently selected by the anode-scan counter. A held
// display register keeps the shown value stable while a conversion runs.
module seg_value_driver #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [13:0] Value,
    input  logic [1:0]  Sel,
    output logic        Busy,
    output logic        Ovf,
    output logic [6:0]  Seg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SHIFT = 4'd13;  // 14 shifts: counts 0..13
    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;

    state_t      r_state;
    state_t      w_state_next;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [15:0] w_bcd_adj;
    logic [3:0]  r_cnt;
    logic        r_ovf_pending;
    logic [15:0] r_disp;
    logic        r_ovf;
    logic [3:0]  w_digit;
    logic        w_blank;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: Load only matters in IDLE; it is never queued.
    always_comb begin
        // NOTE: default first so every path assigns, otherwise a latch is inferred.
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (Load) w_state_next = CONV;
            CONV:    if (r_cnt == LAST_SHIFT) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath and held display register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_bin         <= '0;
            r_bcd         <= '0;
            r_cnt         <= '0;
            r_ovf_pending <= 1'b0;
            r_disp        <= '0;
            r_ovf         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                IDLE: begin
                    if (Load) begin
                        r_bin         <= Value;
                        r_bcd         <= '0;
                        r_cnt         <= '0;
                        r_ovf_pending <= (Value > 14'd9999);
                    end
                end
                CONV: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 4'd1;
                end
                COMMIT: begin
                    r_disp <= r_bcd;
                    r_ovf  <= r_ovf_pending;
                end
                default: ;
            endcase
        end
    end

    // Pick the selected digit and decide whether it is a blanked leading zero.
    always_comb begin
        w_digit = r_disp[3:0];
        w_blank = 1'b0;
        case (Sel)
            2'd0: begin
                w_digit = r_disp[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_digit = r_disp[7:4];
                w_blank = (r_disp[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_disp[11:8];
                w_blank = (r_disp[15:8] == 8'd0);
            end
            default: begin
                w_digit = r_disp[15:12];
                w_blank = (r_disp[15:12] == 4'd0);
            end
        endcase
        if (!BLANK_LZ) w_blank = 1'b0;
    end

    // Cathode decode; combinational so it tracks Sel with no cycle lag.
    always_comb begin
        Seg = SEG_OFF;
        if (r_ovf) begin
            Seg = SEG_DASH;
        end else if (!w_blank) begin
            case (w_digit)
                4'd0:    Seg = 7'b1000000;
                4'd1:    Seg = 7'b1111001;
                4'd2:    Seg = 7'b0100100;
                4'd3:    Seg = 7'b0110000;
                4'd4:    Seg = 7'b0011001;
                4'd5:    Seg = 7'b0010010;
                4'd6:    Seg = 7'b0000010;
                4'd7:    Seg = 7'b1111000;
                4'd8:    Seg = 7'b0000000;
                4'd9:    Seg = 7'b0010000;
                default: Seg = SEG_OFF;
            endcase
        end
    end

    assign Busy = (r_state != IDLE);
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_seg_value_driver.sv
// Testbench for seg_value_driver: two instances (leading-zero blanking on
// and off) share all inputs. Expected cathodes come from a decimal model of
// the shown value; table rows hold hand-derived patterns for key values.
module tb_seg_value_driver;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        Load  = 1'b0;
    logic [13:0] Value = '0;
    logic [1:0]  Sel   = '0;
    logic        busy_b, ovf_b, busy_n, ovf_n;
    logic [6:0]  seg_b, seg_n;

    int checks = 0;
    int errors = 0;
    int model_val = 0;   // value the display should currently show
    bit model_ovf = 1'b0;

    typedef struct {
        int         value;
        logic [6:0] seg [4];   // Sel 0..3 with blanking enabled
        logic       ovf;
    } vec_t;

    seg_value_driver #(.BLANK_LZ(1'b1)) dut_b (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Value(Value), .Sel(Sel),
        .Busy(busy_b), .Ovf(ovf_b), .Seg(seg_b)
    );

    seg_value_driver #(.BLANK_LZ(1'b0)) dut_n (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Value(Value), .Sel(Sel),
        .Busy(busy_n), .Ovf(ovf_n), .Seg(seg_n)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] digit_pattern(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Decimal model: digit sel of val, dash on overflow, blank leading zeros.
    function automatic logic [6:0] exp_seg(input int val, input bit ovf, input int sel, input bit blank);
        int p;
        p = 1;
        for (int i = 0; i < sel; i++) p = p * 10;
        if (ovf) return 7'b0111111;
        if (blank && sel > 0 && val < p) return 7'b1111111;
        return digit_pattern((val / p) % 10);
    endfunction

    // Sweep Sel on both instances against the model. Call at a falling edge.
    task automatic check_display(input string tag);
        for (int s = 0; s < 4; s++) begin
            Sel = s[1:0];
            #1;
            check($sformatf("%s seg_blank sel%0d", tag, s), seg_b, exp_seg(model_val, model_ovf, s, 1'b1));
            check($sformatf("%s seg_noblank sel%0d", tag, s), seg_n, exp_seg(model_val, model_ovf, s, 1'b0));
        end
        check({tag, " ovf"}, {ovf_n, ovf_b}, {model_ovf, model_ovf});
        check({tag, " busy"}, {busy_n, busy_b}, 2'b00);
    endtask

    // Load v at the next rising edge (E0) and walk through E15. Extra Load
    // pulses with Value=7777 are sampled at edges p1 and p2 (0 = none).
    // Busy must be high after E0..E14, low after E15; Seg must hold the old value.
    task automatic run_load(input int v, input int p1, input int p2);
        int old_val;
        bit old_ovf;
        int s;
        old_val = model_val;
        old_ovf = model_ovf;
        Load  = 1'b1;
        Value = v[13:0];
        @(posedge Clk);
        @(negedge Clk);
        Load  = 1'b0;
        Value = 14'($urandom_range(0, 16383));
        for (int k = 0; k < 15; k++) begin
            s = $urandom_range(0, 3);
            Sel = s[1:0];
            #1;
            check($sformatf("busy after E%0d", k), busy_b, 1'b1);
            check($sformatf("hold after E%0d", k), seg_b, exp_seg(old_val, old_ovf, s, 1'b1));
            Load = (k + 1 == p1) || (k + 1 == p2);
            if (Load) Value = 14'd7777;
            @(posedge Clk);
            @(negedge Clk);
        end
        Load = 1'b0;
        model_val = v;
        model_ovf = (v > 9999);
        check("busy after E15", {busy_n, busy_b}, 2'b00);
    endtask

    initial begin
        vec_t vecs [7];
        int   v;

        vecs[0] = '{value: 1234,  seg: '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, ovf: 1'b0};
        vecs[1] = '{value: 9999,  seg: '{7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}, ovf: 1'b0};
        vecs[2] = '{value: 0,     seg: '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111}, ovf: 1'b0};
        vecs[3] = '{value: 305,   seg: '{7'b0010010, 7'b1000000, 7'b0110000, 7'b1111111}, ovf: 1'b0};
        vecs[4] = '{value: 10000, seg: '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, ovf: 1'b1};
        vecs[5] = '{value: 16383, seg: '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, ovf: 1'b1};
        vecs[6] = '{value: 42,    seg: '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111}, ovf: 1'b0};

        // Reset state while Reset is held.
        @(negedge Clk);
        check_display("reset");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Table-driven vectors against hand-derived patterns.
        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i].value, 0, 0);
            check_display($sformatf("model %0d", vecs[i].value));
            @(negedge Clk);
            for (int s = 0; s < 4; s++) begin
                Sel = s[1:0];
                #1;
                check($sformatf("table %0d sel%0d", vecs[i].value, s), seg_b, vecs[i].seg[s]);
            end
            check($sformatf("table %0d ovf", vecs[i].value), ovf_b, vecs[i].ovf);
            if (vecs[i].value == 305) begin
                Sel = 2'd3;
                #1;
                check("table 305 noblank sel3", seg_n, 7'b1000000);
            end
            @(negedge Clk);
        end

        // Load pulses during Busy (E5, E15) are ignored and not queued.
        run_load(1234, 5, 15);
        @(negedge Clk);
        check("busy not extended after E16", busy_b, 1'b0);
        check_display("load during busy");
        @(negedge Clk);

        // Reset mid-conversion aborts and clears the display immediately.
        run_load(42, 0, 0);
        Load  = 1'b1;
        Value = 14'd8888;
        @(posedge Clk);
        @(negedge Clk);
        Load = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        check("busy before mid reset", busy_b, 1'b1);
        Reset = 1'b1;
        #1;
        model_val = 0;
        model_ovf = 1'b0;
        check("busy on mid reset", busy_b, 1'b0);
        @(negedge Clk);
        check_display("mid reset");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        run_load(56, 0, 0);
        check_display("after reset 56");
        @(negedge Clk);

        // Randomized values against the decimal model.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(10000, 16383);
            else                           v = $urandom_range(0, 9999);
            run_load(v, 0, 0);
            check_display($sformatf("rand %0d", v));
            @(negedge Clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
